player_bullet_controller: RTL and testbench

Owns the pool of player bullets: spawns a bullet on each accepted fire press, moves active bullets up the 640x480 playfield, and retires them when they leave the top edge or an enemy reports a hit. Sits directly upstream of the enemy controllers. Its flat bullet buses feed their collision checks, and their `bullet_hit` vectors (ORed at top level) come back here to free slots.

---
 rtl/game_pkg.sv | 13 +
 rtl/bullet_slot_picker.sv | 20 ++
 rtl/player_bullet_controller.sv | 98 +++++++++
 tb/tb_player_bullet_controller.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Playfield and sprite geometry shared by the player bullet and enemy controllers.
package game_pkg;
    localparam int unsigned SCREEN_W    = 640;
    localparam int unsigned SCREEN_H    = 480;
    localparam int unsigned SPRITE_SIZE = 32;
    localparam int unsigned BULLET_SIZE = 8;
    localparam int unsigned NUM_BULLETS = 8;
    localparam int unsigned COORD_W     = 10;

    // Bullet spawns horizontally centred on the sprite, directly above it.
    localparam int unsigned SPAWN_X_OFF = (SPRITE_SIZE - BULLET_SIZE) / 2;
    localparam int unsigned SPAWN_Y_OFF = BULLET_SIZE;
endpackage

// File: rtl/bullet_slot_picker.sv
// Lowest-index free slot priority encoder over the bullet pool.
module bullet_slot_picker #(
    parameter int unsigned NUM_BULLETS = 8,
    parameter int unsigned IDX_W       = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1
) (
    input  logic [NUM_BULLETS-1:0] active,
    output logic [IDX_W-1:0]       free_idx,
    output logic                   any_free
);
    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
            if (!active[i]) begin
                free_idx = IDX_W'(i);
                any_free = 1'b1;
            end
        end
    end
endmodule

// File: rtl/player_bullet_controller.sv
// Player bullet pool: spawns on fire edges, moves bullets up on move ticks,
// retires them on top exit or enemy hit.
module player_bullet_controller
    import game_pkg::COORD_W, game_pkg::SPAWN_X_OFF, game_pkg::SPAWN_Y_OFF;
#(
    parameter int unsigned NUM_BULLETS   = game_pkg::NUM_BULLETS,
    parameter int unsigned BULLET_SPEED  = 4,
    parameter int unsigned MOVE_PERIOD   = 250_000,
    parameter int unsigned FIRE_COOLDOWN = 2_500_000
) (
    input  logic                           clk25,
    input  logic                           rst,
    input  logic                           enable,
    input  logic                           fire_btn,
    input  logic [COORD_W-1:0]             player_x,
    input  logic [COORD_W-1:0]             player_y,
    input  logic [NUM_BULLETS-1:0]         bullet_hit,
    output logic [COORD_W*NUM_BULLETS-1:0] bullet_x_flat,
    output logic [COORD_W*NUM_BULLETS-1:0] bullet_y_flat,
    output logic [NUM_BULLETS-1:0]         bullet_active_flat
);
    localparam int unsigned IDX_W = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
    localparam int unsigned MV_W  = $clog2(MOVE_PERIOD);
    localparam int unsigned CD_W  = $clog2(FIRE_COOLDOWN + 1);

    logic              fire_prev;
    logic [CD_W-1:0]   cooldown;
    logic [MV_W-1:0]   move_cnt;
    logic [IDX_W-1:0]  free_idx;
    logic              any_free;

    logic              press_ok_c;
    logic              spawn_ok_c;
    logic              tick_c;
    logic [COORD_W-1:0] spawn_x_c;
    logic [COORD_W-1:0] spawn_y_c;

    bullet_slot_picker #(
        .NUM_BULLETS (NUM_BULLETS),
        .IDX_W       (IDX_W)
    ) u_picker (
        .active   (bullet_active_flat),
        .free_idx (free_idx),
        .any_free (any_free)
    );

    // A press is consumed by the edge detector even when the pool is full.
    always_comb begin
        press_ok_c = fire_btn && !fire_prev && enable && (cooldown == '0) && any_free;
        spawn_ok_c = press_ok_c && (player_y >= COORD_W'(SPAWN_Y_OFF));
        tick_c     = (move_cnt == MV_W'(MOVE_PERIOD - 1));
        spawn_x_c  = player_x + COORD_W'(SPAWN_X_OFF);
        spawn_y_c  = player_y - COORD_W'(SPAWN_Y_OFF);
    end

    always_ff @(posedge clk25) begin
        if (rst) begin
            fire_prev          <= 1'b0;
            cooldown           <= '0;
            move_cnt           <= '0;
            bullet_active_flat <= '0;
            bullet_x_flat      <= '0;
            bullet_y_flat      <= '0;
        end else begin
            fire_prev <= fire_btn;
            if (!enable) begin
                cooldown           <= '0;
                move_cnt           <= '0;
                bullet_active_flat <= '0;
            end else begin
                move_cnt <= tick_c ? '0 : move_cnt + MV_W'(1);
                if (press_ok_c)
                    cooldown <= CD_W'(FIRE_COOLDOWN);
                else if (cooldown != '0)
                    cooldown <= cooldown - CD_W'(1);

                // Spawn only targets a slot inactive at cycle start, so it never competes with hit/move.
                for (int i = 0; i < NUM_BULLETS; i++) begin
                    if (bullet_active_flat[i]) begin
                        if (bullet_hit[i]) begin
                            bullet_active_flat[i] <= 1'b0;
                        end else if (tick_c) begin
                            if (bullet_y_flat[i*COORD_W +: COORD_W] >= COORD_W'(BULLET_SPEED))
                                bullet_y_flat[i*COORD_W +: COORD_W] <=
                                    bullet_y_flat[i*COORD_W +: COORD_W] - COORD_W'(BULLET_SPEED);
                            else
                                bullet_active_flat[i] <= 1'b0;
                        end
                    end else if (spawn_ok_c && (free_idx == IDX_W'(i))) begin
                        bullet_active_flat[i]               <= 1'b1;
                        bullet_x_flat[i*COORD_W +: COORD_W] <= spawn_x_c;
                        bullet_y_flat[i*COORD_W +: COORD_W] <= spawn_y_c;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_player_bullet_controller.sv
// Directed bench for player_bullet_controller with short move period and cooldown.
module tb_player_bullet_controller;
    localparam int unsigned NB = 8;

    logic          clk25 = 1'b0;
    logic          rst;
    logic          enable;
    logic          fire_btn;
    logic [9:0]    player_x;
    logic [9:0]    player_y;
    logic [NB-1:0] bullet_hit;
    logic [10*NB-1:0] bullet_x_flat;
    logic [10*NB-1:0] bullet_y_flat;
    logic [NB-1:0] bullet_active_flat;

    int checks   = 0;
    int failures = 0;

    player_bullet_controller #(
        .NUM_BULLETS   (NB),
        .BULLET_SPEED  (4),
        .MOVE_PERIOD   (4),
        .FIRE_COOLDOWN (10)
    ) dut (
        .clk25              (clk25),
        .rst                (rst),
        .enable             (enable),
        .fire_btn           (fire_btn),
        .player_x           (player_x),
        .player_y           (player_y),
        .bullet_hit         (bullet_hit),
        .bullet_x_flat      (bullet_x_flat),
        .bullet_y_flat      (bullet_y_flat),
        .bullet_active_flat (bullet_active_flat)
    );

    always #20 clk25 = ~clk25;

    task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk25);
            #1;
        end
    endtask

    function automatic logic [9:0] bx(input int i);
        return bullet_x_flat[i*10 +: 10];
    endfunction

    function automatic logic [9:0] by(input int i);
        return bullet_y_flat[i*10 +: 10];
    endfunction

    // Clean restart: the next posedge is the first enabled cycle with move counter at 0.
    task automatic restart();
        rst = 1'b1; enable = 1'b0; fire_btn = 1'b0; bullet_hit = '0;
        cyc(1);
        rst = 1'b0; enable = 1'b1;
    endtask

    // One accepted press, then wait out the cooldown.
    task automatic fire_press();
        fire_btn = 1'b1;
        cyc(1);
        fire_btn = 1'b0;
        cyc(10);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; fire_btn = 1'b0; bullet_hit = '0;
        player_x = 10'd300; player_y = 10'd440;

        // Reset held with fire toggling
        for (int k = 0; k < 3; k++) begin
            fire_btn = k[0] ? 1'b0 : 1'b1;
            cyc(1);
            check_eq("rst_active", 80'(bullet_active_flat), 80'h0);
            check_eq("rst_x", 80'(bullet_x_flat), 80'h0);
            check_eq("rst_y", 80'(bullet_y_flat), 80'h0);
        end

        // Single shot, cooldown, second bullet
        restart();
        player_x = 10'd300; player_y = 10'd440; fire_btn = 1'b1;
        cyc(1);
        check_eq("shot_active", 80'(bullet_active_flat), 80'h01);
        check_eq("shot_x0", 80'(bx(0)), 80'd312);
        check_eq("shot_y0", 80'(by(0)), 80'd432);
        fire_btn = 1'b0;
        cyc(2);
        check_eq("shot_y0_pretick", 80'(by(0)), 80'd432);
        cyc(1);
        check_eq("shot_y0_tick1", 80'(by(0)), 80'd428);
        cyc(1);
        fire_btn = 1'b1;
        cyc(1);
        check_eq("cooldown_ignore", 80'(bullet_active_flat), 80'h01);
        fire_btn = 1'b0;
        cyc(2);
        check_eq("shot_y0_tick2", 80'(by(0)), 80'd424);
        cyc(3);
        fire_btn = 1'b1;
        cyc(1);
        fire_btn = 1'b0;
        check_eq("second_active", 80'(bullet_active_flat), 80'h03);
        check_eq("second_y0_tick3", 80'(by(0)), 80'd420);
        check_eq("second_x1", 80'(bx(1)), 80'd312);
        check_eq("second_y1_nomove", 80'(by(1)), 80'd432);

        // Top exit and spawn suppressed near top
        restart();
        player_x = 10'd100; player_y = 10'd10; fire_btn = 1'b1;
        cyc(1);
        check_eq("top_spawn_y", 80'(by(0)), 80'd2);
        check_eq("top_spawn_x", 80'(bx(0)), 80'd112);
        fire_btn = 1'b0;
        cyc(3);
        check_eq("top_exit_active", 80'(bullet_active_flat), 80'h00);
        check_eq("top_exit_hold_y", 80'(by(0)), 80'd2);
        cyc(7);
        player_y = 10'd5; fire_btn = 1'b1;
        cyc(1);
        check_eq("low_y_nospawn", 80'(bullet_active_flat), 80'h00);
        fire_btn = 1'b0;
        cyc(1);
        player_y = 10'd440; fire_btn = 1'b1;
        cyc(1);
        check_eq("low_y_cooldown", 80'(bullet_active_flat), 80'h00);
        fire_btn = 1'b0;
        cyc(8);
        fire_btn = 1'b1;
        cyc(1);
        fire_btn = 1'b0;
        check_eq("after_cd_active", 80'(bullet_active_flat), 80'h01);
        check_eq("after_cd_y0", 80'(by(0)), 80'd432);

        // Hit frees a slot; same-cycle press goes to the next free slot
        restart();
        player_x = 10'd300; player_y = 10'd440;
        repeat (3) fire_press();
        check_eq("three_active", 80'(bullet_active_flat), 80'h07);
        bullet_hit = 8'b0000_0010; fire_btn = 1'b1;
        cyc(1);
        check_eq("hit_and_fire", 80'(bullet_active_flat), 80'h0D);
        bullet_hit = '0; fire_btn = 1'b0;
        cyc(10);
        fire_btn = 1'b1;
        cyc(1);
        check_eq("reuse_slot1", 80'(bullet_active_flat), 80'h0F);
        fire_btn = 1'b0; bullet_hit = 8'h80;
        cyc(1);
        check_eq("hit_inactive", 80'(bullet_active_flat), 80'h0F);
        bullet_hit = '0;
        cyc(9);

        // Full pool
        repeat (4) fire_press();
        check_eq("pool_full", 80'(bullet_active_flat), 80'hFF);
        fire_btn = 1'b1;
        cyc(1);
        check_eq("ninth_dropped", 80'(bullet_active_flat), 80'hFF);
        fire_btn = 1'b0; bullet_hit = 8'h10;
        cyc(1);
        bullet_hit = '0;
        check_eq("hit_slot4", 80'(bullet_active_flat), 80'hEF);
        fire_btn = 1'b1;
        cyc(1);
        check_eq("slot4_respawn", 80'(bullet_active_flat), 80'hFF);
        check_eq("slot4_y", 80'(by(4)), 80'd432);

        // Enable drop with fire held
        enable = 1'b0;
        cyc(1);
        check_eq("disable_clear", 80'(bullet_active_flat), 80'h00);
        enable = 1'b1;
        cyc(3);
        check_eq("held_no_fire", 80'(bullet_active_flat), 80'h00);
        fire_btn = 1'b0;
        cyc(1);
        fire_btn = 1'b1;
        cyc(1);
        fire_btn = 1'b0;
        check_eq("refire_active", 80'(bullet_active_flat), 80'h01);
        check_eq("refire_x0", 80'(bx(0)), 80'd312);
        check_eq("refire_y0", 80'(by(0)), 80'd432);

        // Reset mid-flight
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check_eq("midrst_active", 80'(bullet_active_flat), 80'h00);
        check_eq("midrst_x", 80'(bullet_x_flat), 80'h0);
        check_eq("midrst_y", 80'(bullet_y_flat), 80'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
